// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
// Module   : present_pkg
// Brief    : Shared constants and types for the PRESENT key schedule.
//            INV_SBOX exists only when PRESENT_KS_INVERSE_EN is defined.
// Revision : 1.0
// ============================================================================
package present_pkg;

    localparam int ROT_AMT     = 61;
    localparam int XOR_OFS_80  = 15;
    localparam int XOR_OFS_128 = 62;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

`ifdef PRESENT_KS_INVERSE_EN
    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRECOMP = 2'd1,
        EMIT    = 2'd2
    } ks_state_e;

    function automatic int xor_ofs(input int key_w);
        return (key_w == 128) ? XOR_OFS_128 : XOR_OFS_80;
    endfunction

endpackage
`default_nettype wire

// File: rtl/present_key_step.sv
`default_nettype none
// ============================================================================
// Module   : present_key_step
// Brief    : One combinational PRESENT key update, forward or (with
//            PRESENT_KS_INVERSE_EN) inverse, selected by dir.
// Revision : 1.0
// ============================================================================
module present_key_step
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic [KEY_W-1:0] key,
    input  logic [4:0]       i,
    input  logic             dir,
    output logic [KEY_W-1:0] next_key
);
    localparam int C_OFS = xor_ofs(KEY_W);

    logic [KEY_W-1:0] w_fwd;

    always_comb begin
        w_fwd = {key[KEY_W-1-ROT_AMT:0], key[KEY_W-1 -: ROT_AMT]};
        w_fwd[KEY_W-1 -: 4] = SBOX[w_fwd[KEY_W-1 -: 4]];
        // The 128-bit schedule substitutes the two top nibbles.
        if (KEY_W == 128) w_fwd[KEY_W-5 -: 4] = SBOX[w_fwd[KEY_W-5 -: 4]];
        w_fwd[C_OFS +: 5] = w_fwd[C_OFS +: 5] ^ i;
    end

`ifdef PRESENT_KS_INVERSE_EN
    logic [KEY_W-1:0] w_t;
    logic [KEY_W-1:0] w_inv;

    always_comb begin
        w_t = key;
        w_t[C_OFS +: 5] = w_t[C_OFS +: 5] ^ i;
        w_t[KEY_W-1 -: 4] = INV_SBOX[w_t[KEY_W-1 -: 4]];
        if (KEY_W == 128) w_t[KEY_W-5 -: 4] = INV_SBOX[w_t[KEY_W-5 -: 4]];
        w_inv = {w_t[ROT_AMT-1:0], w_t[KEY_W-1:ROT_AMT]};
    end

    assign next_key = dir ? w_inv : w_fwd;
`else
    logic w_unused_dir;
    assign w_unused_dir = dir;
    assign next_key     = w_fwd;
`endif

endmodule
`default_nettype wire

// File: rtl/present_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : present_key_sched
// Brief    : Sequential PRESENT round-key generator with valid/ready streaming.
//            PRESENT_KS_INVERSE_EN adds last-to-first emission via inv_mode.
// Revision : 1.0
// ============================================================================
module present_key_sched
    import present_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 31,
    parameter int RK_W   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             inv_mode,
    output logic [RK_W-1:0]  rk_out,
    output logic [4:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done
);
    localparam logic [5:0] C_ROUNDS = 6'(ROUNDS);
    localparam logic [5:0] C_LAST   = 6'(ROUNDS + 1);

    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
        $error("present_key_sched: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_key_sched: ROUNDS must be in 1..31");
    end
    if (RK_W != 64) begin : g_bad_rk_w
        $error("present_key_sched: RK_W must be 64");
    end

    ks_state_e        r_state, w_state_nxt;
    logic [KEY_W-1:0] r_key, w_key_nxt, w_step_key;
    logic [5:0]       r_ctr, w_ctr_nxt;
    logic             r_done, w_done_nxt;
    logic             w_inv, w_accept_inv, w_step_dir, w_last;
    logic [4:0]       w_step_i;

`ifdef PRESENT_KS_INVERSE_EN
    logic r_inv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inv <= 1'b0;
        end else if (r_state == IDLE && key_valid) begin
            r_inv <= inv_mode;
        end
    end

    assign w_inv        = r_inv;
    assign w_accept_inv = inv_mode;
    // PRECOMP always runs forward; only inverse EMIT steps backwards with ctr-1.
    assign w_step_dir   = (r_state == EMIT) && r_inv;
    assign w_step_i     = w_step_dir ? (r_ctr[4:0] - 5'd1) : r_ctr[4:0];
`else
    logic w_unused_inv;
    assign w_unused_inv = inv_mode;
    assign w_inv        = 1'b0;
    assign w_accept_inv = 1'b0;
    assign w_step_dir   = 1'b0;
    assign w_step_i     = r_ctr[4:0];
`endif

    assign w_last = w_inv ? (r_ctr == 6'd1) : (r_ctr == C_LAST);

    present_key_step #(
        .KEY_W (KEY_W)
    ) u_step (
        .key      (r_key),
        .i        (w_step_i),
        .dir      (w_step_dir),
        .next_key (w_step_key)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_ctr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_ctr   <= w_ctr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_ctr_nxt   = r_ctr;
        w_done_nxt  = 1'b0;
        key_ready   = 1'b0;
        rk_valid    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                key_ready = 1'b1;
                busy      = 1'b0;
                if (key_valid) begin
                    w_key_nxt   = key_in;
                    w_ctr_nxt   = 6'd1;
                    w_state_nxt = w_accept_inv ? PRECOMP : EMIT;
                end
            end
`ifdef PRESENT_KS_INVERSE_EN
            PRECOMP: begin
                w_key_nxt = w_step_key;
                w_ctr_nxt = r_ctr + 6'd1;
                if (r_ctr == C_ROUNDS) w_state_nxt = EMIT;
            end
`endif
            EMIT: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_key_nxt = w_step_key;
                        w_ctr_nxt = w_inv ? (r_ctr - 6'd1) : (r_ctr + 6'd1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Index ROUNDS+1 = 32 does not fit the 5-bit port and reads back as 0.
    assign rk_out = rk_valid ? r_key[KEY_W-1 -: RK_W] : '0;
    assign rk_idx = rk_valid ? r_ctr[4:0] : 5'd0;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_present_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_present_key_sched
// Brief    : Directed self-checking bench for present_key_sched (80/128-bit,
//            31 rounds, plus a 3-round instance for back-to-back keys).
// Revision : 1.0
// ============================================================================
module tb_present_key_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Shared stimulus for the 80-bit and 128-bit 31-round instances
    logic [127:0] kin;
    logic         kv, sel, inv, rr;
    logic [63:0]  rk80, rk128;
    logic [4:0]   idx80, idx128;
    logic         v80, v128, kr80, kr128, b80, b128, d80, d128;

    // 3-round instance
    logic [79:0]  kin3;
    logic         kv3, rr3;
    logic [63:0]  rk3;
    logic [4:0]   idx3;
    logic         v3, kr3, b3, d3;

    present_key_sched #(.KEY_W(80), .ROUNDS(31), .RK_W(64)) u_dut80 (
        .clk(clk), .rst(rst), .key_in(kin[79:0]), .key_valid(kv & ~sel),
        .key_ready(kr80), .inv_mode(inv), .rk_out(rk80), .rk_idx(idx80),
        .rk_valid(v80), .rk_ready(rr), .busy(b80), .done(d80)
    );

    present_key_sched #(.KEY_W(128), .ROUNDS(31), .RK_W(64)) u_dut128 (
        .clk(clk), .rst(rst), .key_in(kin), .key_valid(kv & sel),
        .key_ready(kr128), .inv_mode(inv), .rk_out(rk128), .rk_idx(idx128),
        .rk_valid(v128), .rk_ready(rr), .busy(b128), .done(d128)
    );

    present_key_sched #(.KEY_W(80), .ROUNDS(3), .RK_W(64)) u_dut3 (
        .clk(clk), .rst(rst), .key_in(kin3), .key_valid(kv3),
        .key_ready(kr3), .inv_mode(1'b0), .rk_out(rk3), .rk_idx(idx3),
        .rk_valid(v3), .rk_ready(rr3), .busy(b3), .done(d3)
    );

    logic [63:0] m_rk;
    logic [4:0]  m_idx;
    logic        m_v, m_kr, m_d;
    assign m_rk  = sel ? rk128  : rk80;
    assign m_idx = sel ? idx128 : idx80;
    assign m_v   = sel ? v128   : v80;
    assign m_kr  = sel ? kr128  : kr80;
    assign m_d   = sel ? d128   : d80;

    // Reference key-update model (rotate-left-61 written as rotate-right)
    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] t;
        t = 64'hC56B90AD3EF84712;
        return t[63 - 4*x -: 4];
    endfunction

    function automatic logic [79:0] step80(input logic [79:0] k, input int i);
        logic [79:0] r;
        logic [4:0]  c;
        c = 5'(i);
        r = {k[18:0], k[79:19]};
        r[79:76] = sb(r[79:76]);
        r[19:15] = r[19:15] ^ c;
        return r;
    endfunction

    function automatic logic [127:0] step128(input logic [127:0] k, input int i);
        logic [127:0] r;
        logic [4:0]   c;
        c = 5'(i);
        r = {k[66:0], k[127:67]};
        r[127:124] = sb(r[127:124]);
        r[123:120] = sb(r[123:120]);
        r[66:62]   = r[66:62] ^ c;
        return r;
    endfunction

    // Beats captured by collect()
    logic [63:0] got_rk  [64];
    logic [4:0]  got_idx [64];
    int          got_n, got_lat, got_stab;
    logic        got_done, got_done_kr, got_done_v;

    task automatic collect(input logic s, input logic [127:0] key, input logic iv, input bit rnd);
        logic        stall;
        logic [63:0] prk;
        logic [4:0]  pidx;
        got_n = 0; got_lat = -1; got_stab = 0;
        got_done = 1'b0; got_done_kr = 1'b0; got_done_v = 1'b1;
        stall = 1'b0; prk = '0; pidx = '0;
        @(posedge clk); #1;
        sel = s; kin = key; inv = iv; kv = 1'b1; rr = 1'b1;
        @(posedge clk); #1;
        kv = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            rr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (m_v && got_lat < 0) got_lat = cyc;
            if (stall && (!m_v || m_rk !== prk || m_idx !== pidx)) got_stab++;
            if (m_d) begin
                got_done = 1'b1; got_done_kr = m_kr; got_done_v = m_v;
                break;
            end
            if (m_v && rr && got_n < 64) begin
                got_rk[got_n] = m_rk; got_idx[got_n] = m_idx; got_n++;
            end
            stall = m_v && !rr; prk = m_rk; pidx = m_idx;
            @(posedge clk); #1;
        end
        rr = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (v80 !== 1'b0) $display("FAIL reset_rk_valid: got %b expected 0", v80); else n_pass++;
        n_checks++; if (rk80 !== 64'd0) $display("FAIL reset_rk_out: got %h expected 0", rk80); else n_pass++;
        n_checks++; if (idx80 !== 5'd0) $display("FAIL reset_rk_idx: got %0d expected 0", idx80); else n_pass++;
        n_checks++; if (b80 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", b80); else n_pass++;
        n_checks++; if (d80 !== 1'b0) $display("FAIL reset_done: got %b expected 0", d80); else n_pass++;
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++; if (kr80 !== 1'b1) $display("FAIL reset_key_ready: got %b expected 1", kr80); else n_pass++;
        n_checks++; if (kr3 !== 1'b1 || b3 !== 1'b0) $display("FAIL reset_dut3: got ready=%b busy=%b expected 1/0", kr3, b3); else n_pass++;
    endtask

    task automatic test_forward80();
        logic [79:0] k;
        int          err;
        collect(1'b0, 128'd0, 1'b0, 1'b0);
        n_checks++; if (got_lat !== 1) $display("FAIL fwd80_latency: got %0d expected 1", got_lat); else n_pass++;
        n_checks++; if (got_n !== 32) $display("FAIL fwd80_beats: got %0d expected 32", got_n); else n_pass++;
        n_checks++; if (got_rk[0] !== 64'h0 || got_idx[0] !== 5'd1) $display("FAIL fwd80_idx1: got %h/%0d expected 0/1", got_rk[0], got_idx[0]); else n_pass++;
        n_checks++; if (got_rk[1] !== 64'hC000000000000000) $display("FAIL fwd80_idx2: got %h expected c000000000000000", got_rk[1]); else n_pass++;
        n_checks++; if (got_rk[2] !== 64'h5000180000000001) $display("FAIL fwd80_idx3: got %h expected 5000180000000001", got_rk[2]); else n_pass++;
        k = '0; err = 0;
        for (int j = 0; j < 32; j++) begin
            if (got_rk[j] !== k[79:16] || got_idx[j] !== 5'(j + 1)) err++;
            k = step80(k, j + 1);
        end
        n_checks++; if (err !== 0) $display("FAIL fwd80_sequence: got %0d bad beats expected 0", err); else n_pass++;
        n_checks++; if (got_done !== 1'b1 || got_done_kr !== 1'b1 || got_done_v !== 1'b0)
            $display("FAIL fwd80_done: got done=%b ready=%b valid=%b expected 1/1/0", got_done, got_done_kr, got_done_v); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [79:0] k;
        int          err;
        collect(1'b0, 128'd0, 1'b0, 1'b1);
        n_checks++; if (got_n !== 32) $display("FAIL bp_beats: got %0d expected 32", got_n); else n_pass++;
        n_checks++; if (got_stab !== 0) $display("FAIL bp_stable: got %0d unstable stalls expected 0", got_stab); else n_pass++;
        k = '0; err = 0;
        for (int j = 0; j < 32; j++) begin
            if (got_rk[j] !== k[79:16] || got_idx[j] !== 5'(j + 1)) err++;
            k = step80(k, j + 1);
        end
        n_checks++; if (err !== 0) $display("FAIL bp_sequence: got %0d bad beats expected 0", err); else n_pass++;
        n_checks++; if (got_done !== 1'b1) $display("FAIL bp_done: got %b expected 1", got_done); else n_pass++;
    endtask

    task automatic test_inverse();
        logic [63:0] fw [32];
        logic [79:0] k;
        int          err;
        k = '0;
        for (int j = 0; j < 32; j++) begin
            fw[j] = k[79:16];
            k = step80(k, j + 1);
        end
        collect(1'b0, 128'd0, 1'b1, 1'b0);
        err = 0;
`ifdef PRESENT_KS_INVERSE_EN
        n_checks++; if (got_lat !== 32) $display("FAIL inv_latency: got %0d expected 32", got_lat); else n_pass++;
        for (int j = 0; j < 32; j++)
            if (got_rk[j] !== fw[31 - j] || got_idx[j] !== 5'(32 - j)) err++;
        n_checks++; if (got_rk[31] !== 64'h0) $display("FAIL inv_last: got %h expected 0", got_rk[31]); else n_pass++;
`else
        n_checks++; if (got_lat !== 1) $display("FAIL inv_ignored_latency: got %0d expected 1", got_lat); else n_pass++;
        for (int j = 0; j < 32; j++)
            if (got_rk[j] !== fw[j] || got_idx[j] !== 5'(j + 1)) err++;
`endif
        n_checks++; if (got_n !== 32) $display("FAIL inv_beats: got %0d expected 32", got_n); else n_pass++;
        n_checks++; if (err !== 0) $display("FAIL inv_sequence: got %0d bad beats expected 0", err); else n_pass++;
        n_checks++; if (got_done !== 1'b1) $display("FAIL inv_done: got %b expected 1", got_done); else n_pass++;
    endtask

    task automatic test_key128();
        logic [127:0] k;
        int           err;
        collect(1'b1, 128'd0, 1'b0, 1'b0);
        n_checks++; if (got_n !== 32) $display("FAIL k128_beats: got %0d expected 32", got_n); else n_pass++;
        n_checks++; if (got_rk[1] !== 64'hCC00000000000000) $display("FAIL k128_idx2: got %h expected cc00000000000000", got_rk[1]); else n_pass++;
        k = '0; err = 0;
        for (int j = 0; j < 32; j++) begin
            if (got_rk[j] !== k[127:64] || got_idx[j] !== 5'(j + 1)) err++;
            k = step128(k, j + 1);
        end
        n_checks++; if (err !== 0) $display("FAIL k128_zero_seq: got %0d bad beats expected 0", err); else n_pass++;
        collect(1'b1, {128{1'b1}}, 1'b0, 1'b0);
        k = {128{1'b1}}; err = 0;
        for (int j = 0; j < 32; j++) begin
            if (got_rk[j] !== k[127:64] || got_idx[j] !== 5'(j + 1)) err++;
            k = step128(k, j + 1);
        end
        n_checks++; if (got_n !== 32 || err !== 0) $display("FAIL k128_ones_seq: got %0d beats %0d bad expected 32 0", got_n, err); else n_pass++;
        sel = 1'b0;
    endtask

    task automatic test_async_reset();
        logic found, seen_done;
        found = 1'b0; seen_done = 1'b0;
        @(posedge clk); #1;
        sel = 1'b0; kin = '0; inv = 1'b0; kv = 1'b1; rr = 1'b1;
        @(posedge clk); #1;
        kv = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (m_v && m_idx == 5'd10) begin found = 1'b1; break; end
        end
        n_checks++; if (found !== 1'b1) $display("FAIL arst_reach_idx10: got %b expected 1", found); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (v80 !== 1'b0 || rk80 !== 64'd0 || idx80 !== 5'd0)
            $display("FAIL arst_outputs: got valid=%b rk=%h idx=%0d expected 0/0/0", v80, rk80, idx80); else n_pass++;
        n_checks++; if (b80 !== 1'b0) $display("FAIL arst_busy: got %b expected 0", b80); else n_pass++;
        repeat (3) begin
            @(negedge clk);
            if (d80) seen_done = 1'b1;
        end
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (d80) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b0) $display("FAIL arst_no_done: got %b expected 0", seen_done); else n_pass++;
        n_checks++; if (kr80 !== 1'b1) $display("FAIL arst_key_ready: got %b expected 1", kr80); else n_pass++;
        collect(1'b0, 128'd0, 1'b0, 1'b0);
        n_checks++; if (got_idx[0] !== 5'd1 || got_rk[0] !== 64'd0)
            $display("FAIL arst_restart: got idx=%0d rk=%h expected 1/0", got_idx[0], got_rk[0]); else n_pass++;
        n_checks++; if (got_n !== 32) $display("FAIL arst_restart_beats: got %0d expected 32", got_n); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [79:0] ka, kb, k;
        logic [63:0] exp_rk [8];
        int          beat_cyc [8];
        int          done_cyc [2];
        logic [63:0] b_rk [8];
        logic [4:0]  b_idx [8];
        int          nb, nd, err;
        logic        drop, kr_at_done;
        ka = {80{1'b1}};
        kb = 80'h0123_4567_89AB_CDEF_1357;
        k = ka;
        for (int j = 0; j < 4; j++) begin exp_rk[j] = k[79:16]; k = step80(k, j + 1); end
        k = kb;
        for (int j = 0; j < 4; j++) begin exp_rk[j + 4] = k[79:16]; k = step80(k, j + 1); end
        nb = 0; nd = 0; drop = 1'b0; kr_at_done = 1'b0;
        @(posedge clk); #1;
        kin3 = ka; kv3 = 1'b1; rr3 = 1'b1;
        @(posedge clk); #1;
        kin3 = kb;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (v3 && nb < 8) begin
                b_rk[nb] = rk3; b_idx[nb] = idx3; beat_cyc[nb] = c; nb++;
            end
            if (d3) begin
                if (nd < 2) done_cyc[nd] = c;
                if (nd == 0) kr_at_done = kr3;
                nd++;
                if (kv3) drop = 1'b1;
            end
            @(posedge clk); #1;
            if (drop) begin kv3 = 1'b0; drop = 1'b0; end
        end
        kv3 = 1'b0;
        n_checks++; if (nb !== 8) $display("FAIL b2b_beats: got %0d expected 8", nb); else n_pass++;
        n_checks++; if (nd !== 2) $display("FAIL b2b_done_count: got %0d expected 2", nd); else n_pass++;
        n_checks++; if (kr_at_done !== 1'b1) $display("FAIL b2b_ready_at_done: got %b expected 1", kr_at_done); else n_pass++;
        err = 0;
        for (int j = 0; j < 8 && j < nb; j++) begin
            if (b_rk[j] !== exp_rk[j] || b_idx[j] !== 5'((j % 4) + 1)) err++;
            if (beat_cyc[j] !== ((j < 4) ? j + 1 : j + 2)) err++;
        end
        n_checks++; if (err !== 0) $display("FAIL b2b_sequence: got %0d bad beats expected 0", err); else n_pass++;
        n_checks++; if (nd >= 2 && (done_cyc[0] !== 5 || done_cyc[1] !== 10))
            $display("FAIL b2b_done_cycles: got %0d,%0d expected 5,10", done_cyc[0], done_cyc[1]); else n_pass++;
    endtask

    initial begin
        rst = 1'b0; kin = '0; kv = 1'b0; sel = 1'b0; inv = 1'b0; rr = 1'b1;
        kin3 = '0; kv3 = 1'b0; rr3 = 1'b1;
        test_reset();
        test_forward80();
        test_backpressure();
        test_inverse();
        test_key128();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
